// File: rtl/cme341_pkg.sv
// cme341_pkg: shared constants, defaults and fetch-FSM state type
// for the CME341 pipelined core.
package cme341_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    FILL1,
    FILL2,
    RUN,
    FLUSH1,
    FLUSH2
  } fetch_state_t;

  // Each accepted jump kills two slots; clamp instead of wrapping.
  function automatic logic [7:0] sat_add2(input logic [7:0] c);
    return (c >= 8'hFE) ? 8'hFF : c + 8'd2;
  endfunction

endpackage

// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if: sequencer/ROM/decoder side bundle of the fetch pipe.
// master = sequencer+decoder, slave = fetch_pipe.
interface fetch_pipe_if
  import cme341_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0] pm_address;
  logic [DW-1:0] pm_data;
  logic          jump_taken;
  logic          hold;
  logic [AW-1:0] address_pipe;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_address;
  logic          ir_valid;
  logic          flush_pipeline;
  logic [7:0]    flush_count;

  modport master (
    output pm_address,
    output pm_data,
    output jump_taken,
    output hold,
    input  address_pipe,
    input  ir,
    input  ir_address,
    input  ir_valid,
    input  flush_pipeline,
    input  flush_count
  );

  modport slave (
    input  pm_address,
    input  pm_data,
    input  jump_taken,
    input  hold,
    output address_pipe,
    output ir,
    output ir_address,
    output ir_valid,
    output flush_pipeline,
    output flush_count
  );

endinterface

// File: rtl/fetch_flush_ctrl.sv
// fetch_flush_ctrl: fill/run/flush FSM plus optional killed-slot
// counter (enabled by FETCH_FLUSH_CNT_EN).
module fetch_flush_ctrl
  import cme341_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       jump_taken,
  output logic       slot_valid,
  output logic       ir_valid,
  output logic       flush_pipeline,
  output logic [7:0] flush_count
);

  fetch_state_t state;
  fetch_state_t state_n;
  logic         flush_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FILL1;
      ir_valid       <= 1'b0;
      flush_pipeline <= 1'b0;
    end else if (!hold) begin
      state          <= state_n;
      ir_valid       <= slot_valid;
      flush_pipeline <= flush_n;
    end
  end

  // slot_valid says whether the word landing in ir on this edge is real.
  always_comb begin
    state_n    = state;
    slot_valid = 1'b0;
    flush_n    = 1'b0;
    unique case (state)
      FILL1: state_n = FILL2;
      FILL2: begin
        state_n    = RUN;
        slot_valid = 1'b1;
      end
      RUN: begin
        if (jump_taken) begin
          state_n = FLUSH1;
          flush_n = 1'b1;
        end else begin
          slot_valid = 1'b1;
        end
      end
      FLUSH1: begin
        state_n = FLUSH2;
        flush_n = 1'b1;
      end
      FLUSH2: begin
        state_n    = RUN;
        slot_valid = 1'b1;
      end
      default: state_n = FILL1;
    endcase
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic [7:0] cnt;
  logic       jump_acc;

  assign jump_acc = (state == RUN) && jump_taken && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'h00;
    end else if (jump_acc) begin
      cnt <= sat_add2(cnt);
    end
  end

  assign flush_count = cnt;
`else
  assign flush_count = 8'h00;
`endif

endmodule

// File: rtl/fetch_pipe.sv
// fetch_pipe: two-stage fetch pipe pairing ROM words with their address.
// Optional flush counter: define FETCH_FLUSH_CNT_EN.
module fetch_pipe
  import cme341_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic         clk,
  input logic         reset,
  fetch_pipe_if.slave bus
);

  logic [AW-1:0] address_pipe;
  logic [AW-1:0] ir_address;
  logic [DW-1:0] ir;
  logic          slot_valid;
  logic          ir_valid;
  logic          flush_pipeline;
  logic [7:0]    flush_count;

  fetch_flush_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .hold           (bus.hold),
    .jump_taken     (bus.jump_taken),
    .slot_valid     (slot_valid),
    .ir_valid       (ir_valid),
    .flush_pipeline (flush_pipeline),
    .flush_count    (flush_count)
  );

  // Killed or not-yet-filled slots carry a NOP so the decoder stays idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      address_pipe <= '0;
      ir_address   <= '0;
      ir           <= DW'(NOP_OPCODE);
    end else if (!bus.hold) begin
      address_pipe <= bus.pm_address;
      ir_address   <= address_pipe;
      ir           <= slot_valid ? bus.pm_data : DW'(NOP_OPCODE);
    end
  end

  assign bus.address_pipe   = address_pipe;
  assign bus.ir_address     = ir_address;
  assign bus.ir             = ir;
  assign bus.ir_valid       = ir_valid;
  assign bus.flush_pipeline = flush_pipeline;
  assign bus.flush_count    = flush_count;

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed + random stimulus for fetch_pipe, checked
// against a slot-history reference model.
module tb_fetch_pipe;
  import cme341_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_pipe_if bus ();

  fetch_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom [256];

  // Registered ROM; it freezes with the rest of the pipe on hold.
  always @(posedge clk) begin
    if (!bus.hold) bus.pm_data <= rom[bus.pm_address];
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] pc;
  logic [7:0] ap_m;
  logic [7:0] ira_m;
  logic [7:0] ir_m;
  logic       v_m;
  logic       fl_m;
  int         n_m;
  int         since_m;
  int         cnt_m;
  int         jumps;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, then compare all outputs.
  task automatic cyc(input logic h, input logic j, input logic r,
                     input logic [7:0] tgt);
    logic       acc;
    logic [7:0] data;
    bus.hold       = h;
    bus.jump_taken = j;
    reset          = r;
    bus.pm_address = pc;
    @(posedge clk);
    if (r) begin
      n_m     = 0;
      since_m = 3;
      ap_m    = 8'h00;
      ira_m   = 8'h00;
      ir_m    = NOP_OPCODE;
      v_m     = 1'b0;
      fl_m    = 1'b0;
      cnt_m   = 0;
      pc      = 8'h00;
    end else if (!h) begin
      acc     = j && v_m;
      data    = rom[ap_m];
      ira_m   = ap_m;
      ap_m    = pc;
      if (n_m < 4) n_m++;
      if (acc) since_m = 1;
      else if (since_m < 9) since_m++;
      v_m  = (n_m >= 2) && (since_m >= 3);
      fl_m = (since_m <= 2);
      ir_m = v_m ? data : NOP_OPCODE;
`ifdef FETCH_FLUSH_CNT_EN
      if (acc) cnt_m = (cnt_m + 2 > 255) ? 255 : cnt_m + 2;
`endif
      if (acc) jumps++;
      pc = acc ? tgt : pc + 8'd1;
    end
    #1;
    chk("ir", 32'(bus.ir), 32'(ir_m));
    chk("ir_address", 32'(bus.ir_address), 32'(ira_m));
    chk("ir_valid", 32'(bus.ir_valid), 32'(v_m));
    chk("flush_pipeline", 32'(bus.flush_pipeline), 32'(fl_m));
    chk("address_pipe", 32'(bus.address_pipe), 32'(ap_m));
    chk("flush_count", 32'(bus.flush_count), 32'(cnt_m));
  endtask

  task automatic run_to(input logic [7:0] a);
    for (int i = 0; i < 40 && !(v_m && ira_m == a); i++)
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 16);
    pc             = 8'h00;
    jumps          = 0;
    cnt_m          = 0;
    bus.hold       = 1'b0;
    bus.jump_taken = 1'b0;
    bus.pm_address = 8'h00;
    reset          = 1'b1;

    // reset, linear fill, taken jump at ir_address 5 to 0x40
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    run_to(8'h05);
    cyc(1'b0, 1'b1, 1'b0, 8'h40);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // hold at ir_address 7 (with an ignored jump), then jump in FLUSH1
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    run_to(8'h07);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h60);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h80);
    cyc(1'b0, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // reset in the middle of a flush
    cyc(1'b0, 1'b1, 1'b0, 8'h20);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // 130 accepted jumps: counter saturation
    jumps = 0;
    for (int i = 0; i < 1000 && jumps < 130; i++)
      cyc(1'b0, v_m, 1'b0, 8'($urandom));
`ifdef FETCH_FLUSH_CNT_EN
    chk("flush_count_sat", 32'(bus.flush_count), 32'hFF);
`else
    chk("flush_count_off", 32'(bus.flush_count), 32'h00);
`endif

    // random mix of hold, jumps and occasional reset
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 99) == 0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
